// File: rtl/axi_master_pkg.sv
// Shared types and AXI encodings for the AXI master bridge.
package axi_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RADDR,
        RDATA,
        WADDR,
        WDATA,
        WRESP
    } state_t;

    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi_master_bridge_beat_checker.sv
// Read-burst beat counter and per-beat error flag generation.
module axi_beat_checker #(
    parameter int MASTER_ID = 0,
    parameter int ID_W      = 4,
    parameter int LEN_W     = 4
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic             clear,
    input  logic             beat,
    input  logic [ID_W-1:0]  rid,
    input  logic [1:0]       rresp,
    input  logic             rlast,
    input  logic [LEN_W-1:0] len,
    output logic             beat_err
);
    import axi_master_pkg::*;

    logic [LEN_W:0] cnt_q;
    logic [LEN_W:0] len_ext;

    assign len_ext = {1'b0, len};

    // Beat index within the current burst; saturates so overrun beats stay flagged.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (beat && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Error for the beat currently on the R channel.
    always_comb begin
        beat_err = (rresp != AXI_RESP_OKAY)
                 | (rid != ID_W'(MASTER_ID))
                 | (rlast && (cnt_q != len_ext))
                 | (!rlast && (cnt_q == len_ext))
                 | (cnt_q > len_ext);
    end

endmodule

// File: rtl/axi_master_bridge.sv
// AXI4 manager bridge: one outstanding read burst or single-beat write at a time.
module axi_master_bridge #(
    parameter int MASTER_ID = 0,
    parameter int ID_W      = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 4
) (
    input  logic                ACLK,
    input  logic                ARESETn,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    input  logic [LEN_W-1:0]    req_len,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_last,
    output logic                resp_err,

    output logic [ID_W-1:0]     M_AWID,
    output logic [ADDR_W-1:0]   M_AWAddr,
    output logic [LEN_W-1:0]    M_AWLen,
    output logic [2:0]          M_AWSize,
    output logic [1:0]          M_AWBurst,
    output logic                M_AWValid,
    input  logic                M_AWReady,

    output logic [DATA_W-1:0]   M_WData,
    output logic [DATA_W/8-1:0] M_WStrb,
    output logic                M_WLast,
    output logic                M_WValid,
    input  logic                M_WReady,

    input  logic [ID_W-1:0]     M_BID,
    input  logic [1:0]          M_BResp,
    input  logic                M_BValid,
    output logic                M_BReady,

    output logic [ID_W-1:0]     M_ARID,
    output logic [ADDR_W-1:0]   M_ARAddr,
    output logic [LEN_W-1:0]    M_ARLen,
    output logic [2:0]          M_ARSize,
    output logic [1:0]          M_ARBurst,
    output logic                M_ARValid,
    input  logic                M_ARReady,

    input  logic [ID_W-1:0]     M_RID,
    input  logic [DATA_W-1:0]   M_RData,
    input  logic [1:0]          M_RResp,
    input  logic                M_RLast,
    input  logic                M_RValid,
    output logic                M_RReady
);
    import axi_master_pkg::*;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   wstrb_q;
    logic [LEN_W-1:0]      len_q;
    logic                  accept;
    logic                  r_hs;
    logic                  b_hs;
    logic                  beat_err;
    logic                  unused_bid;

    // BID is not checked: only one write can be outstanding.
    assign unused_bid = &{1'b0, M_BID};

    assign accept = req_valid && (state_q == IDLE);
    assign r_hs   = M_RValid && M_RReady;
    assign b_hs   = M_BValid && M_BReady;

    // Channel payloads come straight from the request latch, so they hold until handshake.
    assign M_ARID    = ID_W'(MASTER_ID);
    assign M_ARAddr  = addr_q;
    assign M_ARLen   = len_q;
    assign M_ARSize  = AXI_SIZE_WORD;
    assign M_ARBurst = AXI_BURST_INCR;
    assign M_AWID    = ID_W'(MASTER_ID);
    assign M_AWAddr  = addr_q;
    assign M_AWLen   = '0;
    assign M_AWSize  = AXI_SIZE_WORD;
    assign M_AWBurst = AXI_BURST_INCR;
    assign M_WData   = wdata_q;
    assign M_WStrb   = wstrb_q;
    assign M_WLast   = 1'b1;

    // State register.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and channel valid/ready decode from the registered state.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        M_ARValid = 1'b0;
        M_RReady  = 1'b0;
        M_AWValid = 1'b0;
        M_WValid  = 1'b0;
        M_BReady  = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = req_write ? WADDR : RADDR;
                end
            end
            RADDR: begin
                M_ARValid = 1'b1;
                if (M_ARReady) state_d = RDATA;
            end
            RDATA: begin
                M_RReady = 1'b1;
                if (M_RValid && M_RLast) state_d = IDLE;
            end
            WADDR: begin
                M_AWValid = 1'b1;
                if (M_AWReady) state_d = WDATA;
            end
            WDATA: begin
                M_WValid = 1'b1;
                if (M_WReady) state_d = WRESP;
            end
            WRESP: begin
                M_BReady = 1'b1;
                if (M_BValid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch, loaded on accept.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            len_q   <= '0;
        end else if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            len_q   <= req_len;
        end
    end

    // Registered response: one pulse per read beat or write completion.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_last  <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= r_hs || b_hs;
            if (r_hs) begin
                resp_rdata <= M_RData;
                resp_last  <= M_RLast;
                resp_err   <= beat_err;
            end else if (b_hs) begin
                resp_last  <= 1'b1;
                resp_err   <= (M_BResp != AXI_RESP_OKAY);
            end else begin
                resp_last  <= 1'b0;
                resp_err   <= 1'b0;
            end
        end
    end

    axi_beat_checker #(
        .MASTER_ID (MASTER_ID),
        .ID_W      (ID_W),
        .LEN_W     (LEN_W)
    ) u_beat_checker (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .clear    (accept),
        .beat     (r_hs),
        .rid      (M_RID),
        .rresp    (M_RResp),
        .rlast    (M_RLast),
        .len      (len_q),
        .beat_err (beat_err)
    );

endmodule

// File: tb/tb_axi_master_bridge.sv
// Self-checking bench for axi_master_bridge with a procedural AXI slave model.
module tb_axi_master_bridge;

    localparam int MID    = 5;
    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 4;

    logic              ACLK = 1'b0;
    logic              ARESETn;
    logic              req_valid, req_ready, req_write;
    logic [31:0]       req_addr, req_wdata;
    logic [3:0]        req_wstrb, req_len;
    logic              resp_valid, resp_last, resp_err;
    logic [31:0]       resp_rdata;
    logic [3:0]        M_AWID, M_AWLen, M_ARID, M_ARLen, M_BID, M_RID, M_WStrb;
    logic [31:0]       M_AWAddr, M_ARAddr, M_WData, M_RData;
    logic [2:0]        M_AWSize, M_ARSize;
    logic [1:0]        M_AWBurst, M_ARBurst, M_BResp, M_RResp;
    logic              M_AWValid, M_AWReady, M_WLast, M_WValid, M_WReady;
    logic              M_BValid, M_BReady, M_ARValid, M_ARReady;
    logic              M_RLast, M_RValid, M_RReady;

    int checks = 0;
    int errors = 0;

    // Slave-side read beat table, filled by each test before a read.
    logic [31:0] rd_data [32];
    logic [1:0]  rd_resp [32];
    logic [3:0]  rd_id   [32];

    always #5 ACLK = ~ACLK;

    axi_master_bridge #(
        .MASTER_ID (MID),
        .ID_W      (ID_W),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .LEN_W     (LEN_W)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_len(req_len),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_last(resp_last), .resp_err(resp_err),
        .M_AWID(M_AWID), .M_AWAddr(M_AWAddr), .M_AWLen(M_AWLen), .M_AWSize(M_AWSize),
        .M_AWBurst(M_AWBurst), .M_AWValid(M_AWValid), .M_AWReady(M_AWReady),
        .M_WData(M_WData), .M_WStrb(M_WStrb), .M_WLast(M_WLast), .M_WValid(M_WValid), .M_WReady(M_WReady),
        .M_BID(M_BID), .M_BResp(M_BResp), .M_BValid(M_BValid), .M_BReady(M_BReady),
        .M_ARID(M_ARID), .M_ARAddr(M_ARAddr), .M_ARLen(M_ARLen), .M_ARSize(M_ARSize),
        .M_ARBurst(M_ARBurst), .M_ARValid(M_ARValid), .M_ARReady(M_ARReady),
        .M_RID(M_RID), .M_RData(M_RData), .M_RResp(M_RResp), .M_RLast(M_RLast),
        .M_RValid(M_RValid), .M_RReady(M_RReady)
    );

    task automatic cycle();
        @(posedge ACLK);
        @(negedge ACLK);
    endtask

    task automatic idle_inputs();
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0; req_len = 0;
        M_AWReady = 0; M_WReady = 0; M_BID = 0; M_BResp = 0; M_BValid = 0; M_ARReady = 0;
        M_RID = 0; M_RData = 0; M_RResp = 0; M_RLast = 0; M_RValid = 0;
    endtask

    // Present a request at a negedge, expect acceptance, then scramble the request bus.
    task automatic accept_req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input logic [3:0] len);
        req_valid = 1; req_write = wr; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb; req_len = len;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept: req_ready=%0b expected 1", req_ready);
        end
        cycle();
        req_valid = 0; req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'($urandom);
        req_len = 4'($urandom); req_write = 1'($urandom);
    endtask

    task automatic run_read(input logic [31:0] addr, input logic [3:0] len, input int nbeats,
                            input int ar_delay, input int gap_min, input int gap_max, input int abort_after);
        int  gap;
        bit  exp_err, exp_last;
        accept_req(1'b0, addr, 32'h0, 4'h0, len);
        for (int c = 0; c <= ar_delay; c++) begin
            checks++;
            if (M_ARValid !== 1'b1 || M_ARAddr !== addr || M_ARLen !== len || M_ARID !== 4'(MID) ||
                M_ARSize !== 3'b010 || M_ARBurst !== 2'b01 || M_RReady !== 1'b0) begin
                errors++;
                $display("FAIL ar_channel c%0d: valid=%0b addr=%h len=%0d id=%0d size=%0d burst=%0d rready=%0b expected 1 %h %0d %0d 2 1 0",
                         c, M_ARValid, M_ARAddr, M_ARLen, M_ARID, M_ARSize, M_ARBurst, M_RReady, addr, len, MID);
            end
            M_ARReady = (c == ar_delay);
            cycle();
        end
        M_ARReady = 0;
        for (int i = 0; i < nbeats; i++) begin
            gap = $urandom_range(gap_max, gap_min);
            for (int g = 0; g < gap; g++) begin
                cycle();
                checks++;
                if (resp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rd_gap beat %0d: resp_valid=%0b expected 0", i, resp_valid);
                end
            end
            checks++;
            if (M_RReady !== 1'b1 || M_ARValid !== 1'b0 || ((i == 0 || gap > 0) && resp_valid !== 1'b0)) begin
                errors++;
                $display("FAIL rd_beat_pre %0d: rready=%0b arvalid=%0b resp_valid=%0b expected 1 0 0",
                         i, M_RReady, M_ARValid, resp_valid);
            end
            M_RValid = 1; M_RData = rd_data[i]; M_RResp = rd_resp[i]; M_RID = rd_id[i];
            M_RLast = (i == nbeats - 1);
            cycle();
            M_RValid = 0; M_RLast = 0; M_RData = $urandom;
            exp_last = (i == nbeats - 1);
            exp_err  = (rd_resp[i] != 2'b00) || (rd_id[i] != 4'(MID)) ||
                       (exp_last && i != int'(len)) || (i == int'(len) && !exp_last) || (i > int'(len));
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== rd_data[i] || resp_last !== exp_last || resp_err !== exp_err) begin
                errors++;
                $display("FAIL rd_resp beat %0d: valid=%0b data=%h last=%0b err=%0b expected 1 %h %0b %0b",
                         i, resp_valid, resp_rdata, resp_last, resp_err, rd_data[i], exp_last, exp_err);
            end
            if (i == abort_after) begin
                ARESETn = 0;
                cycle();
                ARESETn = 1;
                checks++;
                if ({M_ARValid, M_AWValid, M_WValid, M_BReady, M_RReady, resp_valid, resp_err, resp_last} !== 8'h00) begin
                    errors++;
                    $display("FAIL mid_reset: ar=%0b aw=%0b w=%0b b=%0b r=%0b rv=%0b re=%0b rl=%0b expected all 0",
                             M_ARValid, M_AWValid, M_WValid, M_BReady, M_RReady, resp_valid, resp_err, resp_last);
                end
                for (int k = 0; k < 4; k++) begin
                    cycle();
                    checks++;
                    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
                        errors++;
                        $display("FAIL post_reset_quiet %0d: resp_valid=%0b req_ready=%0b expected 0 1", k, resp_valid, req_ready);
                    end
                end
                return;
            end
        end
        checks++;
        if (req_ready !== 1'b1 || M_RReady !== 1'b0) begin
            errors++;
            $display("FAIL rd_done: req_ready=%0b rready=%0b expected 1 0", req_ready, M_RReady);
        end
        cycle();
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_single_pulse: resp_valid=%0b expected 0", resp_valid);
        end
    endtask

    task automatic run_write(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                             input int aw_delay, input int w_delay, input int b_delay, input logic [1:0] bresp);
        bit exp_err;
        exp_err = (bresp != 2'b00);
        accept_req(1'b1, addr, wdata, wstrb, 4'($urandom));
        for (int c = 0; c <= aw_delay; c++) begin
            checks++;
            if (M_AWValid !== 1'b1 || M_AWAddr !== addr || M_AWLen !== 4'd0 || M_AWID !== 4'(MID) ||
                M_AWSize !== 3'b010 || M_AWBurst !== 2'b01 || M_WValid !== 1'b0) begin
                errors++;
                $display("FAIL aw_channel c%0d: valid=%0b addr=%h len=%0d id=%0d size=%0d burst=%0d wvalid=%0b expected 1 %h 0 %0d 2 1 0",
                         c, M_AWValid, M_AWAddr, M_AWLen, M_AWID, M_AWSize, M_AWBurst, M_WValid, addr, MID);
            end
            M_AWReady = (c == aw_delay);
            cycle();
        end
        M_AWReady = 0;
        for (int c = 0; c <= w_delay; c++) begin
            checks++;
            if (M_WValid !== 1'b1 || M_WData !== wdata || M_WStrb !== wstrb || M_WLast !== 1'b1 || M_AWValid !== 1'b0) begin
                errors++;
                $display("FAIL w_channel c%0d: valid=%0b data=%h strb=%h last=%0b awvalid=%0b expected 1 %h %h 1 0",
                         c, M_WValid, M_WData, M_WStrb, M_WLast, M_AWValid, wdata, wstrb);
            end
            M_WReady = (c == w_delay);
            cycle();
        end
        M_WReady = 0;
        for (int c = 0; c <= b_delay; c++) begin
            checks++;
            if (M_BReady !== 1'b1 || M_WValid !== 1'b0 || resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL b_wait c%0d: bready=%0b wvalid=%0b resp_valid=%0b expected 1 0 0",
                         c, M_BReady, M_WValid, resp_valid);
            end
            M_BValid = (c == b_delay); M_BResp = bresp; M_BID = 4'(MID);
            cycle();
        end
        M_BValid = 0;
        checks++;
        if (resp_valid !== 1'b1 || resp_last !== 1'b1 || resp_err !== exp_err || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL wr_resp: valid=%0b last=%0b err=%0b req_ready=%0b expected 1 1 %0b 1",
                     resp_valid, resp_last, resp_err, req_ready, exp_err);
        end
        cycle();
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_single_pulse: resp_valid=%0b expected 0", resp_valid);
        end
    endtask

    task automatic fill_clean_read(input int n);
        for (int i = 0; i < n; i++) begin
            rd_data[i] = $urandom; rd_resp[i] = 2'b00; rd_id[i] = 4'(MID);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        ARESETn = 0;
        cycle();
        cycle();
        checks++;
        if ({M_ARValid, M_AWValid, M_WValid, M_BReady, M_RReady, resp_valid, resp_err, resp_last} !== 8'h00 ||
            req_ready !== 1'b1 || M_ARAddr !== 32'h0 || M_ARLen !== 4'h0 || M_WData !== 32'h0 || M_WStrb !== 4'h0) begin
            errors++;
            $display("FAIL reset: ar=%0b aw=%0b w=%0b b=%0b r=%0b rv=%0b re=%0b rl=%0b rq=%0b addr=%h len=%0d wd=%h ws=%h expected zeros with rq=1",
                     M_ARValid, M_AWValid, M_WValid, M_BReady, M_RReady, resp_valid, resp_err, resp_last,
                     req_ready, M_ARAddr, M_ARLen, M_WData, M_WStrb);
        end
        ARESETn = 1;
        cycle();
    endtask

    task automatic test_read_single();
        rd_data[0] = 32'hDEADBEEF; rd_resp[0] = 2'b00; rd_id[0] = 4'(MID);
        run_read(32'h0000_0010, 4'd0, 1, 0, 0, 0, -1);
    endtask

    task automatic test_read_burst_delays();
        for (int i = 0; i < 4; i++) begin
            rd_data[i] = 32'(i + 1); rd_resp[i] = 2'b00; rd_id[i] = 4'(MID);
        end
        run_read(32'h0000_1000, 4'd3, 4, 2, 1, 1, -1);
    endtask

    task automatic test_write_delayed_aw();
        run_write(32'h0000_0200, 32'h1234_5678, 4'b0011, 3, 0, 0, 2'b00);
    endtask

    task automatic test_write_slverr();
        run_write(32'h0000_0300, 32'hCAFE_F00D, 4'b1111, 0, 1, 2, 2'b10);
    endtask

    task automatic test_early_rlast();
        fill_clean_read(4);
        run_read(32'h0000_2000, 4'd3, 2, 0, 0, 1, -1);
        fill_clean_read(1);
        run_read(32'h0000_2040, 4'd0, 1, 0, 0, 0, -1);
    endtask

    task automatic test_late_rlast_and_id();
        fill_clean_read(4);
        rd_id[0] = 4'(MID + 1);
        rd_resp[1] = 2'b11;
        run_read(32'h0000_3000, 4'd1, 4, 1, 0, 1, -1);
    endtask

    task automatic test_reset_mid_read();
        fill_clean_read(4);
        run_read(32'h0000_4000, 4'd3, 4, 0, 0, 0, 0);
        fill_clean_read(4);
        run_read(32'h0000_4100, 4'd3, 4, 1, 0, 2, -1);
    endtask

    task automatic test_back_to_back();
        int  len, nbeats, sel;
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(1, 0) == 1) begin
                run_write($urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom), $urandom_range(3, 0),
                          $urandom_range(2, 0), $urandom_range(2, 0), 2'($urandom_range(3, 0) == 0 ? $urandom_range(3, 1) : 0));
            end else begin
                len = $urandom_range(15, 0);
                sel = $urandom_range(7, 0);
                nbeats = (sel == 0) ? $urandom_range(len + 1, 1) : (sel == 1) ? len + 1 + $urandom_range(3, 1) : len + 1;
                fill_clean_read(nbeats);
                for (int i = 0; i < nbeats; i++) begin
                    if ($urandom_range(15, 0) == 0) rd_resp[i] = 2'($urandom_range(3, 1));
                    if ($urandom_range(15, 0) == 0) rd_id[i] = 4'($urandom_range(15, 0));
                end
                run_read($urandom & 32'hFFFF_FFFC, 4'(len), nbeats, $urandom_range(2, 0), 0, 2, -1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_single();
        test_read_burst_delays();
        test_write_delayed_aw();
        test_write_slverr();
        test_early_rlast();
        test_late_rlast_and_id();
        test_reset_mid_read();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
